// File: rtl/adxl362_pkg.sv
// Shared constants and types for the ADXL362 SPI register master.
// Holds the command bytes, the accelerometer data register map and the
// transaction state encoding used by the master FSM.
package adxl362_pkg;

    // Command bytes (first byte of every frame)
    localparam logic [7:0] CMD_READ  = 8'h0B;
    localparam logic [7:0] CMD_WRITE = 8'h0A;

    // Y/Z data register addresses
    localparam logic [7:0] Y_LSB = 8'h10;
    localparam logic [7:0] Y_MSB = 8'h11;
    localparam logic [7:0] Z_LSB = 8'h12;
    localparam logic [7:0] Z_MSB = 8'h13;

    // Number of SCLK cycles in one register transaction
    localparam logic [4:0] FRAME_BITS = 5'd24;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    // Builds {cmd, addr, data}; a read always clocks out 0x00 as its data byte.
    function automatic logic [23:0] build_frame(input logic       rw,
                                                input logic [7:0] addr,
                                                input logic [7:0] wdata);
        logic [7:0] cmd;
        logic [7:0] dat;
        cmd = rw ? CMD_READ : CMD_WRITE;
        dat = rw ? 8'h00 : wdata;
        return {cmd, addr, dat};
    endfunction

endpackage

// File: rtl/adxl362_spi_master_sclk_div.sv
// SCLK half-period timer: counts CLK_DIV clk cycles per half period.
// Emits one-cycle rise/fall strobes alternately (rise first) while enabled.
// Clearing en returns the counter and phase to zero on the next edge.
module spi_sclk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic rise,
    output logic fall
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic          tick;

    // Half-period count and strobe decode; phase 0 means SCLK is currently low.
    always_comb begin
        tick    = en && (cnt_q == CW'(CLK_DIV - 1));
        rise    = tick && !phase_q;
        fall    = tick &&  phase_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!en) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (tick) begin
            cnt_d   = '0;
            phase_d = !phase_q;
        end else begin
            cnt_d   = cnt_q + 1'b1;
        end
    end

    // Counter and phase registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/adxl362_spi_master.sv
// SPI mode-0 master running one 24-bit ADXL362 register read or write per start.
// Latency: CS low one cycle after acceptance, done 1+49*CLK_DIV+CS_GAP cycles after it.
// A start while busy is dropped; there is no queueing and no error indication.
module adxl362_spi_master
    import adxl362_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       CS,
    output logic       SCLK,
    output logic       MOSI,
    input  logic       MISO
);

    localparam int GW = $clog2(CS_GAP + 1);

    state_t         state_q, state_d;
    logic [23:0]    tx_q, tx_d;
    logic [7:0]     rx_q, rx_d;
    logic [4:0]     bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]  gap_cnt_q, gap_cnt_d;
    logic           rw_q, rw_d;
    logic           cs_q, cs_d;
    logic           sclk_q, sclk_d;
    logic           mosi_q, mosi_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [7:0]     rdata_q, rdata_d;

    logic           div_en;
    logic           sclk_rise;
    logic           sclk_fall;

    // The divider starts once CS is actually low, so the first rising edge
    // lands a full half period after CS falls; it keeps running through HOLD
    // so the CS release is timed by the same strobe train.
    always_comb begin
        div_en = ((state_q == SETUP) && !cs_q) ||
                 (state_q == SHIFT) ||
                 (state_q == HOLD);
    end

    spi_sclk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_div (
        .clk   (clk),
        .reset (reset),
        .en    (div_en),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    // Next-state and next-output logic for the transaction sequencer.
    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        rw_d      = rw_q;
        cs_d      = cs_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rdata_d   = rdata_q;

        case (state_q)
            IDLE: begin
                if (start && !busy_q) begin
                    state_d   = SETUP;
                    tx_d      = build_frame(rw, addr, wdata);
                    rw_d      = rw;
                    rx_d      = 8'h00;
                    bit_cnt_d = 5'd0;
                end
            end

            SETUP: begin
                cs_d   = 1'b0;
                busy_d = 1'b1;
                sclk_d = 1'b0;
                mosi_d = tx_q[23];
                if (sclk_rise) begin
                    sclk_d    = 1'b1;
                    bit_cnt_d = 5'd1;
                    rx_d      = {rx_q[6:0], MISO};
                    state_d   = SHIFT;
                end
            end

            SHIFT: begin
                if (sclk_rise) begin
                    // MISO is sampled on the edge that raises SCLK; only the
                    // last eight samples survive in the 8-bit shifter.
                    sclk_d    = 1'b1;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    rx_d      = {rx_q[6:0], MISO};
                end else if (sclk_fall) begin
                    sclk_d = 1'b0;
                    if (bit_cnt_q == FRAME_BITS) begin
                        state_d = HOLD;
                        mosi_d  = 1'b0;
                    end else begin
                        tx_d   = {tx_q[22:0], 1'b0};
                        mosi_d = tx_q[22];
                    end
                end
            end

            HOLD: begin
                if (sclk_rise) begin
                    cs_d      = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end
            end

            GAP: begin
                if (gap_cnt_q == GW'(CS_GAP - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (rw_q) begin
                        rdata_d = rx_q;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            tx_q      <= 24'h000000;
            rx_q      <= 8'h00;
            bit_cnt_q <= 5'd0;
            gap_cnt_q <= '0;
            rw_q      <= 1'b0;
            cs_q      <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rdata_q   <= 8'h00;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            rw_q      <= rw_d;
            cs_q      <= cs_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign rdata = rdata_q;
    assign CS    = cs_q;
    assign SCLK  = sclk_q;
    assign MOSI  = mosi_q;

endmodule

// File: tb/tb_adxl362_spi_master.sv
// Bench for adxl362_spi_master: two instances (CLK_DIV 4 and 2) each talk to a
// small ADXL362 slave model; frames and read data are scoreboarded, edge times
// are compared with the timing formulas.
module tb_adxl362_spi_master;

    logic       clk = 1'b0;
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    bit         tb_go = 1'b0;

    logic [1:0] rst_s;
    logic [1:0] start_s;
    logic [1:0] rw_s;
    logic [7:0] addr_s  [2];
    logic [7:0] wdata_s [2];
    logic [1:0] busy_s;
    logic [1:0] done_s;
    logic [7:0] rdata_s [2];
    logic [1:0] cs_s;
    logic [1:0] sclk_s;
    logic [1:0] mosi_s;
    logic [1:0] miso_s;

    // Scoreboard queues, one pair per instance
    logic [23:0] exp_frame_q [2][$];
    logic [7:0]  exp_rd_q    [2][$];
    logic [7:0]  model_rd    [2];
    bit          abort_s     [2];

    // Slave model state
    int          s_cnt   [2];
    logic [23:0] s_shift [2];
    logic [7:0]  s_data  [2];
    bit          cs_p    [2];
    bit          sclk_p  [2];
    bit          mosi_p  [2];
    bit          glitch  [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int DIV = (g == 0) ? 4 : 2;
        adxl362_spi_master #(
            .CLK_DIV (DIV),
            .CS_GAP  (4)
        ) u_dut (
            .clk   (clk),
            .reset (rst_s[g]),
            .start (start_s[g]),
            .rw    (rw_s[g]),
            .addr  (addr_s[g]),
            .wdata (wdata_s[g]),
            .busy  (busy_s[g]),
            .done  (done_s[g]),
            .rdata (rdata_s[g]),
            .CS    (cs_s[g]),
            .SCLK  (sclk_s[g]),
            .MOSI  (mosi_s[g]),
            .MISO  (miso_s[g])
        );
    end

    function automatic logic [7:0] regval(input logic [7:0] a);
        case (a)
            8'h10:   return 8'd5;
            8'h11:   return 8'd10;
            8'h12:   return 8'd15;
            8'h13:   return 8'd20;
            default: return 8'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave model, protocol checker and done-side scoreboard for both instances.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!tb_go) begin
                cs_p[g] = 1'b1; sclk_p[g] = 1'b0; mosi_p[g] = 1'b0;
                s_cnt[g] = 0; glitch[g] = 1'b0; miso_s[g] = 1'b0;
            end else begin
                if (cs_s[g]) begin
                    if (!cs_p[g] && !abort_s[g]) begin
                        check("rise_count", s_cnt[g], 24);
                        check("frame_pending", exp_frame_q[g].size() > 0, 1);
                        if (exp_frame_q[g].size() > 0)
                            check("mosi_frame", s_shift[g], exp_frame_q[g].pop_front());
                        check("mosi_stable", glitch[g], 0);
                    end
                    s_cnt[g] = 0; glitch[g] = 1'b0; miso_s[g] = 1'b0;
                end else begin
                    if (!sclk_p[g] && sclk_s[g]) begin
                        s_shift[g] = {s_shift[g][22:0], mosi_s[g]};
                        s_cnt[g]++;
                    end else if (sclk_p[g] && !sclk_s[g]) begin
                        if (s_cnt[g] == 16) s_data[g] = regval(s_shift[g][7:0]);
                        if (s_cnt[g] >= 16 && s_cnt[g] <= 23)
                            miso_s[g] = s_data[g][23 - s_cnt[g]];
                        else
                            miso_s[g] = 1'b0;
                    end
                    if (sclk_p[g] && sclk_s[g] && (mosi_s[g] != mosi_p[g])) glitch[g] = 1'b1;
                end
                if (done_s[g]) begin
                    check("done_pending", exp_rd_q[g].size() > 0, 1);
                    if (exp_rd_q[g].size() > 0)
                        check("rdata_at_done", rdata_s[g], exp_rd_q[g].pop_front());
                    check("busy_at_done", busy_s[g], 0);
                end
                cs_p[g] = cs_s[g]; sclk_p[g] = sclk_s[g]; mosi_p[g] = mosi_s[g];
            end
        end
    end

    task automatic push_exp(input int g, input bit r, input logic [7:0] a, input logic [7:0] w);
        logic [23:0] f;
        f = r ? {8'h0B, a, 8'h00} : {8'h0A, a, w};
        exp_frame_q[g].push_back(f);
        if (r) model_rd[g] = regval(a);
        exp_rd_q[g].push_back(model_rd[g]);
    endtask

    // One transaction with edge timing checks; hold keeps start high through done.
    task automatic do_txn(input int g, input bit r, input logic [7:0] a,
                          input logic [7:0] w, input bit hold);
        int dv, t, t_csf, t_r1, t_csr, t_done, t_csf2, n_fall, n_low;
        bit busy1, prev_cs;
        dv = (g == 0) ? 4 : 2;
        t_csf = -1; t_r1 = -1; t_csr = -1; t_done = -1; t_csf2 = -1;
        n_fall = 0; busy1 = 1'b0; prev_cs = 1'b1;
        @(negedge clk);
        push_exp(g, r, a, w);
        rw_s[g] = r; addr_s[g] = a; wdata_s[g] = w; start_s[g] = 1'b1;
        t = cyc + 1;
        for (int n = 0; n < 600 && t_done < 0; n++) begin
            @(negedge clk);
            if (!hold) start_s[g] = 1'b0;
            if (cyc == t + 1) busy1 = busy_s[g];
            if (prev_cs && !cs_s[g]) n_fall++;
            prev_cs = cs_s[g];
            if (t_csf < 0 && !cs_s[g]) t_csf = cyc;
            if (t_r1 < 0 && sclk_s[g]) t_r1 = cyc;
            if (t_csf >= 0 && t_csr < 0 && cs_s[g]) t_csr = cyc;
            if (done_s[g]) t_done = cyc;
        end
        check("busy_rise", busy1, 1);
        check("cs_fall_time", t_csf, t + 1);
        check("rise1_time", t_r1, t + 1 + dv);
        check("cs_rise_time", t_csr, t + 1 + 49 * dv);
        check("done_time", t_done, t + 1 + 49 * dv + 4);
        check("frames_before_done", n_fall, 1);
        if (hold) begin
            push_exp(g, r, a, w);
            for (int n = 0; n < 20 && t_csf2 < 0; n++) begin
                @(negedge clk);
                if (!cs_s[g]) t_csf2 = cyc;
            end
            start_s[g] = 1'b0;
            check("second_cs_fall", t_csf2, t_done + 2);
            t_done = -1;
            for (int n = 0; n < 600 && t_done < 0; n++) begin
                @(negedge clk);
                if (done_s[g]) t_done = cyc;
            end
            check("second_done_time", t_done, t_csf2 + 49 * dv + 4);
            n_low = 0;
            repeat (20) begin
                @(negedge clk);
                if (!cs_s[g]) n_low++;
            end
            check("no_third_frame", n_low, 0);
        end
    endtask

    initial begin
        int t, n_done;
        rst_s = 2'b11; start_s = 2'b00; rw_s = 2'b00;
        for (int g = 0; g < 2; g++) begin
            addr_s[g] = 8'h00; wdata_s[g] = 8'h00; model_rd[g] = 8'h00; abort_s[g] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("rst_cs",    cs_s[g],    1);
            check("rst_sclk",  sclk_s[g],  0);
            check("rst_mosi",  mosi_s[g],  0);
            check("rst_busy",  busy_s[g],  0);
            check("rst_done",  done_s[g],  0);
            check("rst_rdata", rdata_s[g], 0);
        end
        rst_s = 2'b00;
        tb_go = 1'b1;
        repeat (2) @(negedge clk);

        do_txn(0, 1'b1, 8'h10, 8'h00, 1'b0);   // Y_LSB -> 0x05
        do_txn(0, 1'b1, 8'h13, 8'hFF, 1'b0);   // Z_MSB -> 0x14
        do_txn(1, 1'b1, 8'h13, 8'h00, 1'b0);   // Z_MSB at CLK_DIV=2
        do_txn(1, 1'b1, 8'h12, 8'h00, 1'b0);   // Z_LSB at CLK_DIV=2
        do_txn(0, 1'b1, 8'h11, 8'h00, 1'b0);   // Y_MSB -> 0x0A
        do_txn(0, 1'b0, 8'h2D, 8'h02, 1'b0);   // write keeps rdata 0x0A
        do_txn(0, 1'b1, 8'h12, 8'h00, 1'b1);   // start held -> two frames

        // Reset landing on the edge of the 10th SCLK rise
        @(negedge clk);
        rw_s[0] = 1'b1; addr_s[0] = 8'h10; start_s[0] = 1'b1;
        t = cyc + 1;
        @(negedge clk);
        start_s[0] = 1'b0;
        for (int n = 0; n < 200 && cyc < t + 1 + 19 * 4 - 1; n++) @(negedge clk);
        abort_s[0] = 1'b1;
        rst_s[0] = 1'b1;
        @(negedge clk);
        check("mid_rst_cs",    cs_s[0],    1);
        check("mid_rst_sclk",  sclk_s[0],  0);
        check("mid_rst_busy",  busy_s[0],  0);
        check("mid_rst_rdata", rdata_s[0], 0);
        check("mid_rst_mosi",  mosi_s[0],  0);
        rst_s[0] = 1'b0;
        model_rd[0] = 8'h00;
        n_done = 0;
        repeat (300) begin
            @(negedge clk);
            if (done_s[0]) n_done++;
        end
        check("no_done_after_abort", n_done, 0);
        abort_s[0] = 1'b0;
        do_txn(0, 1'b1, 8'h11, 8'h00, 1'b0);   // Y_MSB after reset -> 0x0A

        repeat (10) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("frames_drained", exp_frame_q[g].size(), 0);
            check("dones_drained",  exp_rd_q[g].size(), 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
